pulse_sync_rx_multi: RTL and testbench
======================================

# pulse_sync_rx_multi

Parametrised multi-channel receive-side pulse synchronizer. Each of WIDTH channels accepts a toggle-encoded event from a foreign clock domain. It synchronizes the toggle into clk, converts each edge into a queued event, and releases events as single-cycle pulses under downstream `ready` back-pressure. It sits at the destination side of CDC crossings in the logical layer. It replaces fixed 4-bit pulse synchronization where events can arrive in bursts or the consumer can stall.

## Interface
Parameters:
- WIDTH, 4, number of independent channels
- SYNC_STAGES, 2, synchronizer flop depth (legal range 2..4)
- CNT_W, 3, pending-event counter width per channel; max queued events = 2^CNT_W-1

Ports:
- clk  input  1  single clock; all flops on its rising edge
- rst  input  1  asynchronous, active-high reset
- tgl_in  input  WIDTH  foreign-domain toggle per channel; each transition = one event
- ready  input  1  downstream accepts pulses this cycle (shared by all channels)
- clr_ovf  input  1  synchronous clear of all overflow flags
- pulse_out  output  WIDTH  one-cycle event pulses
- ack_tgl  output  WIDTH  registered toggle, flips once per event released; returned to source domain
- overflow  output  WIDTH  sticky; event dropped on a saturated channel
- busy  output  1  OR of (pending != 0) over all channels

## Operation
- Per channel: sync chain sync[0..SYNC_STAGES-1], then edge register last_q, then pending counter cnt[CNT_W-1:0], then ack_tgl flop.
- ev = armed & (sync[SYNC_STAGES-1] ^ last_q). last_q follows sync[SYNC_STAGES-1] every cycle.
- Arming: a shared counter holds armed=0 for SYNC_STAGES+1 cycles after reset release. While unarmed, last_q tracks the chain and no events are generated. A tgl_in level of 1 at reset release therefore produces no spurious event.
- pulse_out[i] = ready & (cnt != 0) (combinational from registered cnt and ready).
- cnt update per cycle:
  - ev & ~pulse_out: cnt+1.
  - ~ev & pulse_out: cnt-1.
  - ev & pulse_out: cnt unchanged.
  - Neither: hold.
- Saturation: if cnt == 2^CNT_W-1 and ev & ~pulse_out, the event is dropped, cnt holds, and overflow[i] sets.
- ack_tgl[i] flips on every cycle pulse_out[i]=1.
- overflow[i] clears when clr_ovf=1. If a set condition occurs in the same cycle, set wins.
- Channels are fully independent. There is no arbitration, and several pulse_out bits may be high in the same cycle.

## Timing
- Reset values: pulse_out=0, ack_tgl=0, overflow=0, busy=0, all cnt=0, sync/last_q=0, armed=0.
- Latency: tgl_in changes before edge E.
  - sync[SYNC_STAGES-1] updates at edge E+SYNC_STAGES-1.
  - cnt increments at edge E+SYNC_STAGES.
  - pulse_out is high in the cycle following edge E+SYNC_STAGES if ready=1.
- Throughput: one pulse per channel per cycle while ready=1 and cnt>0.
- The source must hold each toggle level for at least SYNC_STAGES+1 clk cycles. Faster toggling is out of contract and may lose events.
- Reset asserted mid-operation clears all state immediately, including queued events and overflow. Re-arming is required after release.
- ready low: cnt keeps accumulating up to saturation, and no pulses or ack_tgl flips occur.

## Structure
- Package pulse_sync_pkg: default constants for WIDTH/SYNC_STAGES/CNT_W and the arming-count width function (clog2 of SYNC_STAGES+2).
- Sub-module pulse_sync_rx_chan: one channel (sync chain, edge detect, counter, ack_tgl, overflow). It takes armed, ready and clr_ovf as inputs and is instantiated WIDTH times in a generate loop.
- Top level holds the arming counter and the busy OR-reduction.

## Test plan
- Single event: tgl_in[0] 0→1 held, SYNC_STAGES=2, ready=1 → exactly one pulse_out[0], in the cycle after edge E+2; ack_tgl[0]=1; busy high for 1 cycle.
- Reset-release with tgl_in=4'b1010 → no pulses, cnt all 0 after arming; a subsequent toggle on bit 1 → one pulse on bit 1.
- Burst with stall: ready=0, 5 events on channel 2 (CNT_W=3) → busy=1, no pulses. Raise ready → 5 consecutive pulses on channel 2; ack_tgl[2] ends at 1.
- Saturation: ready=0, 9 events on channel 3 → cnt=7, overflow[3]=1. Raise ready → 7 pulses. clr_ovf → overflow[3]=0.
- Simultaneous ev and release: cnt=1, ready=1, new event arriving → pulse each cycle, cnt stays 1, then drains to 0.
- Mid-queue reset: cnt=4 on channel 1, assert rst asynchronously → pulse_out, busy, overflow drop to 0 without waiting for clk.

Source files
------------

// File: rtl/pulse_sync_pkg.sv
// Shared defaults and helpers for the multi-channel receive-side pulse synchronizer.
package pulse_sync_pkg;

  localparam int unsigned DEF_WIDTH       = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_CNT_W       = 3;

  // The arming counter must be able to hold the value stages+1.
  function automatic int unsigned arm_cnt_w(input int unsigned stages);
    return $clog2(stages + 2);
  endfunction

endpackage

// File: rtl/pulse_sync_rx_chan.sv
// One receive channel: toggle synchronizer, edge detect, pending-event counter,
// back-pressured pulse release, acknowledge toggle and sticky overflow.
module pulse_sync_rx_chan
  import pulse_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic tgl_in,
  input  logic armed,
  input  logic ready,
  input  logic clr_ovf,
  output logic pulse_out,
  output logic ack_tgl,
  output logic overflow,
  output logic pending
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   last_q;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   ev;
  logic                   ovf_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync   <= '0;
      last_q <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], tgl_in};
      last_q <= sync[SYNC_STAGES-1];
    end
  end

  // last_q keeps tracking while unarmed so a level present at reset release is absorbed.
  assign ev        = armed & (sync[SYNC_STAGES-1] ^ last_q);
  assign pending   = (cnt != '0);
  assign pulse_out = ready & pending;

  always_comb begin
    cnt_nxt = cnt;
    ovf_set = 1'b0;
    if (ev && !pulse_out) begin
      if (cnt == '1) ovf_set = 1'b1;
      else           cnt_nxt = cnt + CNT_W'(1);
    end else if (!ev && pulse_out) begin
      cnt_nxt = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      ack_tgl  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (pulse_out) ack_tgl <= ~ack_tgl;
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/pulse_sync_rx_multi.sv
// Multi-channel receive-side pulse synchronizer: shared post-reset arming counter,
// WIDTH independent channels and a busy summary.
module pulse_sync_rx_multi
  import pulse_sync_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tgl_in,
  input  logic             ready,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] pulse_out,
  output logic [WIDTH-1:0] ack_tgl,
  output logic [WIDTH-1:0] overflow,
  output logic             busy
);

  localparam int unsigned      ARM_W    = arm_cnt_w(SYNC_STAGES);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  logic [ARM_W-1:0] arm_cnt;
  logic             armed;
  logic [WIDTH-1:0] pending;

  // Events stay suppressed until the chains and last_q have settled after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    arm_cnt <= '0;
    else if (arm_cnt != ARM_DONE) arm_cnt <= arm_cnt + ARM_W'(1);
  end

  assign armed = (arm_cnt == ARM_DONE);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    pulse_sync_rx_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .tgl_in   (tgl_in[i]),
      .armed    (armed),
      .ready    (ready),
      .clr_ovf  (clr_ovf),
      .pulse_out(pulse_out[i]),
      .ack_tgl  (ack_tgl[i]),
      .overflow (overflow[i]),
      .pending  (pending[i])
    );
  end

  assign busy = |pending;

endmodule

// File: tb/tb_pulse_sync_rx_multi.sv
// Directed bench for pulse_sync_rx_multi (WIDTH=4, SYNC_STAGES=2, CNT_W=3).
module tb_pulse_sync_rx_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] tgl_in;
  logic       ready;
  logic       clr_ovf;
  logic [3:0] pulse_out;
  logic [3:0] ack_tgl;
  logic [3:0] overflow;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int stray = 0;

  always #5 clk = ~clk;

  pulse_sync_rx_multi #(
    .WIDTH      (4),
    .SYNC_STAGES(2),
    .CNT_W      (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tgl_in   (tgl_in),
    .ready    (ready),
    .clr_ovf  (clr_ovf),
    .pulse_out(pulse_out),
    .ack_tgl  (ack_tgl),
    .overflow (overflow),
    .busy     (busy)
  );

  typedef struct {
    logic       rst;
    logic [3:0] tgl;
    logic       ready;
    logic [3:0] pulse;
    logic [3:0] ack;
    logic [3:0] ovf;
    logic       busy;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic r, input logic [3:0] t, input logic rd,
                              input logic [3:0] p, input logic [3:0] a,
                              input logic [3:0] o, input logic b);
    vec_t v;
    v.rst = r; v.tgl = t; v.ready = rd; v.pulse = p; v.ack = a; v.ovf = o; v.busy = b;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Flip one channel's toggle and hold it for SYNC_STAGES+1 cycles; starts and ends at posedge+1.
  task automatic toggle_hold(input int unsigned ch);
    tgl_in[ch] = ~tgl_in[ch];
    repeat (3) begin
      @(negedge clk);
      if (!ready && pulse_out != 4'h0) stray++;
      @(posedge clk);
    end
    #1;
  endtask

  task automatic drain(input int unsigned ch, input int unsigned n, output logic [15:0] pat);
    pat = '0;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      pat[i] = pulse_out[ch];
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pat;

    for (int i = 0; i < 4; i++)   vecs[i] = mk(1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
    for (int i = 4; i < 7; i++)   vecs[i] = mk(1'b0, 4'h1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
    vecs[7] = mk(1'b0, 4'h1, 1'b1, 4'h1, 4'h0, 4'h0, 1'b1);
    for (int i = 8; i < 10; i++)  vecs[i] = mk(1'b0, 4'h1, 1'b1, 4'h0, 4'h1, 4'h0, 1'b0);
    for (int i = 10; i < 12; i++) vecs[i] = mk(1'b1, 4'hA, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
    for (int i = 12; i < 18; i++) vecs[i] = mk(1'b0, 4'hA, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
    for (int i = 18; i < 21; i++) vecs[i] = mk(1'b0, 4'h8, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
    vecs[21] = mk(1'b0, 4'h8, 1'b1, 4'h2, 4'h0, 4'h0, 1'b1);
    for (int i = 22; i < 24; i++) vecs[i] = mk(1'b0, 4'h8, 1'b1, 4'h0, 4'h2, 4'h0, 1'b0);

    rst = 1'b1; tgl_in = 4'h0; ready = 1'b1; clr_ovf = 1'b0;
    @(negedge clk);
    check("reset_state", {19'd0, pulse_out, ack_tgl, overflow, busy}, 32'd0);
    @(posedge clk); @(posedge clk); #1;

    // Single event on ch0, then reset release with tgl_in=1010 and a ch1 toggle.
    for (int i = 0; i < 24; i++) begin
      rst   = vecs[i].rst;
      tgl_in = vecs[i].tgl;
      ready = vecs[i].ready;
      @(negedge clk);
      check($sformatf("vec%0d", i), {19'd0, pulse_out, ack_tgl, overflow, busy},
            {19'd0, vecs[i].pulse, vecs[i].ack, vecs[i].ovf, vecs[i].busy});
      @(posedge clk); #1;
    end

    // Burst of 5 on ch2 under stall, then drain.
    ready = 1'b0;
    for (int i = 0; i < 5; i++) toggle_hold(2);
    @(negedge clk);
    check("burst_busy", {31'd0, busy}, 32'd1);
    check("burst_nopulse", {28'd0, pulse_out}, 32'h0);
    @(posedge clk); #1;
    ready = 1'b1;
    drain(2, 8, pat);
    check("burst_pattern", {16'd0, pat}, 32'h001F);
    @(negedge clk);
    check("burst_ack", {28'd0, ack_tgl}, 32'h6);
    check("burst_idle", {31'd0, busy}, 32'd0);
    check("burst_ovf", {28'd0, overflow}, 32'h0);
    @(posedge clk); #1;

    // Saturation: 9 events on ch3 with CNT_W=3 keep 7 and flag overflow.
    ready = 1'b0;
    for (int i = 0; i < 9; i++) toggle_hold(3);
    @(negedge clk);
    check("sat_ovf", {28'd0, overflow}, 32'h8);
    check("sat_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    ready = 1'b1;
    drain(3, 10, pat);
    check("sat_pattern", {16'd0, pat}, 32'h007F);
    @(negedge clk);
    check("sat_ack", {28'd0, ack_tgl}, 32'hE);
    check("sat_ovf_sticky", {28'd0, overflow}, 32'h8);
    @(posedge clk); #1;
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    @(negedge clk);
    check("clr_ovf", {28'd0, overflow}, 32'h0);
    check("stall_stray_pulses", stray, 32'd0);
    @(posedge clk); #1;

    // Simultaneous event and release on ch0: count stays at 1 for one cycle.
    ready = 1'b0;
    toggle_hold(0);
    tgl_in[0] = ~tgl_in[0];
    @(posedge clk); #1;
    @(posedge clk); #1;
    ready = 1'b1;
    @(negedge clk);
    check("simul_p0", {28'd0, pulse_out}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("simul_p1", {28'd0, pulse_out}, 32'h1);
    check("simul_busy1", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("simul_p2", {28'd0, pulse_out}, 32'h0);
    check("simul_idle", {31'd0, busy}, 32'd0);
    check("simul_ack", {28'd0, ack_tgl}, 32'hE);
    @(posedge clk); #1;

    // Mid-queue asynchronous reset with 4 events pending on ch1.
    ready = 1'b0;
    for (int i = 0; i < 4; i++) toggle_hold(1);
    #1;
    ready = 1'b1;
    #1;
    check("preq_pulse", {28'd0, pulse_out}, 32'h2);
    check("preq_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("areset_pulse", {28'd0, pulse_out}, 32'h0);
    check("areset_busy", {31'd0, busy}, 32'd0);
    check("areset_ack", {28'd0, ack_tgl}, 32'h0);
    check("areset_ovf", {28'd0, overflow}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
